// File: rtl/mul_div_unit.sv
// Iterative RV32M-style divider: DIV/DIVU/REM/REMU with a restoring
// shift-subtract core, one quotient bit per cycle, and a stall/done handshake.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST    = 6'(XLEN - 1);

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + ONE;
    endfunction

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;     // holds |dividend| and shifts in quotient bits
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;       // |divisor|
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode on the IDLE-cycle inputs.
    logic            in_signed;
    logic            in_dvd_neg;
    logic            in_dvs_neg;
    logic [XLEN-1:0] in_dvd_abs;
    logic [XLEN-1:0] in_dvs_abs;
    logic            in_div_zero;
    logic            in_overflow;

    assign in_signed   = ~i_op[0];
    assign in_dvd_neg  = in_signed & i_dividend[XLEN-1];
    assign in_dvs_neg  = in_signed & i_divisor[XLEN-1];
    assign in_dvd_abs  = in_dvd_neg ? negate(i_dividend) : i_dividend;
    assign in_dvs_abs  = in_dvs_neg ? negate(i_divisor) : i_divisor;
    assign in_div_zero = (i_divisor == '0);
    assign in_overflow = in_signed && (i_dividend == INT_MIN) && (i_divisor == '1);

    // One restoring step: the XLEN+1-bit partial remainder never exceeds
    // 2*|divisor|-1, so its top bit after the subtract is a clean borrow.
    logic [XLEN:0]   part_rem;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quot;
    logic [XLEN-1:0] fix_quot;
    logic [XLEN-1:0] fix_rem;

    assign part_rem  = {rem_q, quot_q[XLEN-1]};
    assign diff      = part_rem - {1'b0, dvs_q};
    assign step_rem  = diff[XLEN] ? part_rem[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quot = {quot_q[XLEN-2:0], ~diff[XLEN]};
    assign fix_quot  = q_neg_q ? negate(step_quot) : step_quot;
    assign fix_rem   = r_neg_q ? negate(step_rem) : step_rem;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        if (i_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        op_d    = op_e'(i_op);
                        quot_d  = in_dvd_abs;
                        rem_d   = '0;
                        dvs_d   = in_dvs_abs;
                        q_neg_d = in_dvd_neg ^ in_dvs_neg;
                        r_neg_d = in_dvd_neg;
                        cnt_d   = '0;
                        if (in_div_zero) begin
                            result_d = i_op[1] ? i_dividend : '1;
                            state_d  = S_DONE;
                        end else if (in_overflow) begin
                            result_d = i_op[1] ? '0 : INT_MIN;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        result_d = op_q[1] ? fix_rem : fix_quot;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_DIV;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // Busy drops in DONE so the stalled instruction retires with the result.
    assign o_busy   = ((state_q == S_IDLE) && i_start && !i_flush) || (state_q == S_CALC);
    assign o_done   = (state_q == S_DONE);
    assign o_result = result_q;

endmodule
